display_clk_en_gen: RTL
=======================

DISPLAY_CLK_EN_GEN -- requirements
Module: display_clk_en_gen

Parameters
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent pixel-clock channels.
REQ-002 SHALL have parameter DIV_W, default 8: width of each channel's divide ratio.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: number of pix_ce pulses before ch_locked asserts.
REQ-004 SHALL have parameter RST_STRETCH, default 4: number of pix_ce pulses after lock before rst_pix deasserts.

Interface
REQ-005 SHALL have clk_sys, input, 1: the only clock; all logic is on its rising edge.
REQ-006 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have div_ratio, input, NUM_CH*DIV_W: per-channel divide ratio N; channel c occupies bits [c*DIV_W +: DIV_W].
REQ-008 SHALL have div_update, input, NUM_CH: per-channel request to load div_ratio.
REQ-009 SHALL have ch_en, input, NUM_CH: per-channel enable, level-sensitive.
REQ-010 SHALL have pix_ce, output, NUM_CH: per-channel one-cycle clock-enable pulse.
REQ-011 SHALL have rst_pix, output, NUM_CH: per-channel active-high pixel-domain reset.
REQ-012 SHALL have ch_locked, output, NUM_CH: per-channel lock indication.
REQ-013 SHALL have update_ack, output, NUM_CH: one-cycle pulse when a new ratio is applied.

Function
REQ-014 SHALL treat every channel as an independent, identical instance; channels share nothing but clk_sys and rst.
REQ-015 SHALL implement a per-channel FSM with states OFF, LOCK, RST_HOLD and RUN.
REQ-016 SHALL treat an effective ratio of N=0 as N=1.
REQ-017 SHALL drive pix_ce high for exactly one cycle every N cycles; with N=1, pix_ce SHALL be continuously high.
REQ-018 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-019 SHALL, in OFF, hold the counter at 0, pix_ce=0, rst_pix=1 and ch_locked=0.
REQ-020 SHALL transition OFF->LOCK when ch_en is sampled high, and SHALL assert the first pix_ce N cycles after that sampling cycle (ch_en seen at cycle 0 gives the first pix_ce at cycle N).
REQ-021 SHALL transition LOCK->RST_HOLD on the LOCK_CYCLES-th pix_ce, asserting ch_locked in the following cycle.
REQ-022 SHALL transition RST_HOLD->RUN on the RST_STRETCH-th pix_ce after entry, deasserting rst_pix in the following cycle.
REQ-023 SHALL, when ch_en is sampled low in any non-OFF state, enter OFF in the next cycle: pix_ce=0, ch_locked=0, rst_pix=1, and any pending update discarded.
REQ-024 SHALL, on div_update in OFF, load the active ratio at that edge and pulse update_ack in the next cycle.
REQ-025 SHALL, on div_update in LOCK, RST_HOLD or RUN, capture div_ratio into a pending register and apply it at the cycle of the next pix_ce, so the current period always completes and the first new period starts after that pix_ce.
REQ-026 SHALL pulse update_ack in the same cycle as the pix_ce at which a pending ratio is applied.
REQ-027 SHALL let a newer div_update overwrite an unapplied pending ratio, producing only one ack.
REQ-028 SHALL give disable priority when div_update and ch_en low coincide: no ack, and the ratio is not loaded.
REQ-029 SHALL leave ch_locked and the FSM state unchanged when a ratio change is applied.
REQ-030 SHALL let the period counter be DIV_W bits wide and wrap from N-1 to 0 with no overflow beyond the ratio range.
REQ-031 SHALL saturate the lock and stretch counters at their terminal values and not wrap them.

Reset
REQ-032 SHALL, with rst high at a clk_sys edge, force every channel to OFF with pix_ce=0, rst_pix=all ones, ch_locked=0, update_ack=0, all counters 0, active ratios=1 and pending flags cleared.
REQ-033 SHALL give rst priority over all inputs, including mid-lock and mid-update.
REQ-034 SHALL, on rst release, resume normally: a channel with ch_en held high enters LOCK on the first post-reset edge.

Verification (NUM_CH=2, DIV_W=8, LOCK_CYCLES=4, RST_STRETCH=2)
REQ-035 SHALL cover reset: hold rst 3 cycles with random inputs -> pix_ce=00, rst_pix=11, ch_locked=00, update_ack=00.
REQ-036 SHALL cover bring-up: ch0 ratio=3 loaded in OFF, ch_en[0] high at cycle 0 -> pix_ce[0] at cycles 3,6,9,12,15,18; ch_locked[0]=1 from cycle 13; rst_pix[0]=0 from cycle 19; ch1 outputs stay at their reset values.
REQ-037 SHALL cover small ratios: ratio 0 and ratio 1 -> pix_ce continuously high after enable; lock at cycle 5; rst_pix low from cycle 7.
REQ-038 SHALL cover glitch-free reload: in RUN with ratio=3, pulse div_update with 5 one cycle after a pix_ce -> next pix_ce 2 cycles later with update_ack coincident, then pix_ce every 5 cycles, ch_locked stays 1.
REQ-039 SHALL cover disable mid-lock with a simultaneous update: drop ch_en[0] after 2 pix_ce while pulsing div_update[0] -> OFF next cycle, no update_ack, re-enable restarts the lock count from 0 using the old ratio.
REQ-040 SHALL cover reset mid-run: both channels in RUN with different ratios, assert rst 1 cycle -> all outputs at reset values the next cycle; with ch_en held, both channels re-lock per REQ-036 timing using ratio=1.

Source files
------------

// File: rtl/display_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : display_clk_en_gen
// Description : Multi-channel pixel clock-enable generator. Each channel
//               divides clk_sys by a programmable ratio N. It produces a
//               one-cycle pix_ce pulse every N cycles. The channel also
//               sequences a lock phase and a reset-stretch phase before it
//               releases its pixel-domain reset.
//
// Ports
//   clk_sys    : in  system clock, all logic on its rising edge
//   rst        : in  synchronous active-high reset
//   div_ratio  : in  per-channel divide ratio, channel c at [c*DIV_W +: DIV_W]
//   div_update : in  per-channel request to load div_ratio
//   ch_en      : in  per-channel level-sensitive enable
//   pix_ce     : out per-channel clock-enable pulse
//   rst_pix    : out per-channel active-high pixel-domain reset
//   ch_locked  : out per-channel lock indication
//   update_ack : out per-channel one-cycle pulse when a new ratio takes effect
//
// Revision    : 1.0 - initial release
// ============================================================================
module display_clk_en_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int RST_STRETCH = 4
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [NUM_CH-1:0]       div_update,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       pix_ce,
    output logic [NUM_CH-1:0]       rst_pix,
    output logic [NUM_CH-1:0]       ch_locked,
    output logic [NUM_CH-1:0]       update_ack
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int STR_W  = $clog2(RST_STRETCH + 1);

    localparam logic [1:0] c_st_off      = 2'd0;
    localparam logic [1:0] c_st_lock     = 2'd1;
    localparam logic [1:0] c_st_rst_hold = 2'd2;
    localparam logic [1:0] c_st_run      = 2'd3;

    localparam logic [DIV_W-1:0]  c_one      = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [LOCK_W-1:0] c_lock_max = LOCK_W'(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] c_lock_end = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [STR_W-1:0]  c_str_max  = STR_W'(RST_STRETCH);
    localparam logic [STR_W-1:0]  c_str_end  = STR_W'(RST_STRETCH - 1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]        state_q, state_d;
        logic [DIV_W-1:0]  cnt_q, cnt_d;
        logic [DIV_W-1:0]  ratio_q, ratio_d;
        logic [DIV_W-1:0]  pend_ratio_q, pend_ratio_d;
        logic              pend_q, pend_d;
        logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
        logic [STR_W-1:0]  str_cnt_q, str_cnt_d;
        logic              pix_ce_q, pix_ce_d;
        logic              rst_pix_q, rst_pix_d;
        logic              locked_q, locked_d;
        logic              ack_q, ack_d;

        logic [DIV_W-1:0]  w_raw_ratio;
        logic [DIV_W-1:0]  w_req_ratio;
        logic              w_last;

        assign w_raw_ratio = div_ratio[c*DIV_W +: DIV_W];
        // A requested ratio of zero behaves as divide-by-one.
        assign w_req_ratio = (w_raw_ratio == '0) ? c_one : w_raw_ratio;
        // The last cycle of the current period. The stored ratio is never 0.
        assign w_last      = (cnt_q == (ratio_q - c_one));

        always_comb begin
            state_d      = state_q;
            cnt_d        = cnt_q;
            ratio_d      = ratio_q;
            pend_ratio_d = pend_ratio_q;
            pend_d       = pend_q;
            lock_cnt_d   = lock_cnt_q;
            str_cnt_d    = str_cnt_q;
            pix_ce_d     = 1'b0;
            rst_pix_d    = rst_pix_q;
            locked_d     = locked_q;
            ack_d        = 1'b0;

            if (state_q == c_st_off) begin
                cnt_d      = '0;
                lock_cnt_d = '0;
                str_cnt_d  = '0;
                rst_pix_d  = 1'b1;
                locked_d   = 1'b0;
                pend_d     = 1'b0;
                // No period is running, so a new ratio can take effect at once.
                if (div_update[c]) begin
                    ratio_d = w_req_ratio;
                    ack_d   = 1'b1;
                end
                if (ch_en[c]) begin
                    state_d = c_st_lock;
                end
            end else if (!ch_en[c]) begin
                // A disable outranks any update in the same cycle and
                // drops a pending one.
                state_d    = c_st_off;
                cnt_d      = '0;
                lock_cnt_d = '0;
                str_cnt_d  = '0;
                rst_pix_d  = 1'b1;
                locked_d   = 1'b0;
                pend_d     = 1'b0;
            end else begin
                cnt_d    = w_last ? '0 : (cnt_q + c_one);
                pix_ce_d = w_last;

                // A pending ratio takes effect on the pulse that ends the
                // current period, so no period is ever truncated.
                if (w_last && pend_q) begin
                    ratio_d = pend_ratio_q;
                    ack_d   = 1'b1;
                    pend_d  = 1'b0;
                end
                // A fresh request replaces any ratio still waiting. If it
                // arrives on the boundary cycle it waits for the next pulse.
                if (div_update[c]) begin
                    pend_d       = 1'b1;
                    pend_ratio_d = w_req_ratio;
                end

                // Sequencing counts the registered pulse, so a status
                // output changes in the cycle after the pulse that
                // completes its count.
                if (pix_ce_q) begin
                    case (state_q)
                        c_st_lock: begin
                            if (lock_cnt_q != c_lock_max) begin
                                lock_cnt_d = lock_cnt_q + 1'b1;
                            end
                            if (lock_cnt_q == c_lock_end) begin
                                state_d  = c_st_rst_hold;
                                locked_d = 1'b1;
                            end
                        end
                        c_st_rst_hold: begin
                            if (str_cnt_q != c_str_max) begin
                                str_cnt_d = str_cnt_q + 1'b1;
                            end
                            if (str_cnt_q == c_str_end) begin
                                state_d   = c_st_run;
                                rst_pix_d = 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end

        always_ff @(posedge clk_sys) begin
            if (rst) begin
                state_q      <= c_st_off;
                cnt_q        <= '0;
                ratio_q      <= c_one;
                pend_ratio_q <= c_one;
                pend_q       <= 1'b0;
                lock_cnt_q   <= '0;
                str_cnt_q    <= '0;
                pix_ce_q     <= 1'b0;
                rst_pix_q    <= 1'b1;
                locked_q     <= 1'b0;
                ack_q        <= 1'b0;
            end else begin
                state_q      <= state_d;
                cnt_q        <= cnt_d;
                ratio_q      <= ratio_d;
                pend_ratio_q <= pend_ratio_d;
                pend_q       <= pend_d;
                lock_cnt_q   <= lock_cnt_d;
                str_cnt_q    <= str_cnt_d;
                pix_ce_q     <= pix_ce_d;
                rst_pix_q    <= rst_pix_d;
                locked_q     <= locked_d;
                ack_q        <= ack_d;
            end
        end

        assign pix_ce[c]     = pix_ce_q;
        assign rst_pix[c]    = rst_pix_q;
        assign ch_locked[c]  = locked_q;
        assign update_ack[c] = ack_q;
    end

endmodule
`default_nettype wire
